// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: word layout, command codes and default panel timing.
// lcd_drv and lcd_bus_rx both use these constants, so the driver and the receiver agree on timing.
package lcd_pkg;

   localparam int         LCD_WORD_W      = 9;
   localparam logic [7:0] CMD_CLEAR       = 8'h01;
   localparam logic [7:0] CMD_HOME        = 8'h02;
   localparam int         T_EN_MIN_CYC    = 23;
   localparam int         T_BUSY_CYC      = 3700;
   localparam int         T_BUSY_LONG_CYC = 152000;

   typedef enum logic [1:0] {
      EV_SHORT,
      EV_BUSY_WR,
      EV_OVERFLOW,
      EV_PUSH
   } rx_event_e;

   // Clear (0x01) and home (0x02/0x03) share data[7:2] == 0.
   // They are the only instructions that take the long busy time.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && ((data & ~(CMD_CLEAR | CMD_HOME)) == 8'h00);
   endfunction

endpackage

// File: rtl/lcd_rx_fifo.sv
// Synchronous show-ahead FIFO for captured LCD words.
// rdata always shows the head entry; push is ignored when full and pop is ignored when empty.
module lcd_rx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/lcd_bus_rx.sv
// HD44780-style LCD bus receiver: captures {rs, data} on each en falling edge, checks en width,
// emulates the panel busy period and presents the captured words on a ready/valid stream.
module lcd_bus_rx
   import lcd_pkg::*;
#(
   parameter int MIN_EN_CYCLES    = T_EN_MIN_CYC,
   parameter int BUSY_CYCLES      = T_BUSY_CYC,
   parameter int BUSY_LONG_CYCLES = T_BUSY_LONG_CYC,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rs_i,
   input  logic                  en_i,
   input  logic [7:0]            lcd_data_i,
   output logic [LCD_WORD_W-1:0] data_o,
   output logic                  data_valid_o,
   input  logic                  host_ready_i,
   output logic                  busy_o,
   output logic                  err_short_pulse_o,
   output logic                  err_busy_write_o,
   output logic                  err_overflow_o
);

   localparam int WC_W  = $clog2(MIN_EN_CYCLES + 1);
   localparam int BT_W  = $clog2(BUSY_LONG_CYCLES + 1);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                  en_q;
   logic                  rs_q;
   logic [7:0]            data_q;
   logic [WC_W-1:0]       width_q;
   logic [BT_W-1:0]       busy_timer;
   logic                  fall;
   logic                  push;
   logic                  pop;
   logic                  reload;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic [LCD_WORD_W-1:0] head;
   rx_event_e             ev;

   // Input sampling stage: the captured word is whatever was sampled while en was still high.
   always_ff @(posedge clk_i) begin
      if (rst_i) en_q <= 1'b0;
      else       en_q <= en_i;
   end

   always_ff @(posedge clk_i) begin
      rs_q   <= rs_i;
      data_q <= lcd_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i)
         width_q <= '0;
      else if (width_q != WC_W'(MIN_EN_CYCLES))
         width_q <= width_q + WC_W'(1);
   end

   assign fall   = en_q & ~en_i;
   assign busy_o = (busy_timer != '0);

   // Priority order matters: a short pulse is never counted as a busy write or an overflow.
   always_comb begin
      ev = EV_PUSH;
      if (width_q < WC_W'(MIN_EN_CYCLES)) ev = EV_SHORT;
      else if (busy_o)                    ev = EV_BUSY_WR;
      else if (fifo_full)                 ev = EV_OVERFLOW;
   end

   assign push   = fall && (ev == EV_PUSH);
   assign reload = fall && ((ev == EV_PUSH) || (ev == EV_OVERFLOW));

   // Event stage: error pulses and busy timer update on the edge where fall is seen.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_short_pulse_o <= 1'b0;
         err_busy_write_o  <= 1'b0;
         err_overflow_o    <= 1'b0;
      end else begin
         err_short_pulse_o <= fall && (ev == EV_SHORT);
         err_busy_write_o  <= fall && (ev == EV_BUSY_WR);
         err_overflow_o    <= fall && (ev == EV_OVERFLOW);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         busy_timer <= '0;
      else if (reload)
         busy_timer <= is_long_cmd(rs_q, data_q) ? BT_W'(BUSY_LONG_CYCLES) : BT_W'(BUSY_CYCLES);
      else if (busy_o)
         busy_timer <= busy_timer - BT_W'(1);
   end

   lcd_rx_fifo #(
      .WIDTH (LCD_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .wdata ({rs_q, data_q}),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign data_valid_o = (fifo_count != '0);
   assign pop          = data_valid_o & host_ready_i;
   assign data_o       = fifo_empty ? '0 : head;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Bench for lcd_bus_rx: directed and randomized LCD bus traffic checked every cycle against a
// transaction-level model (word queue, busy deadline, pulse run length).
module tb_lcd_bus_rx;
   import lcd_pkg::*;

   localparam int MIN_EN    = 23;
   localparam int BUSY      = 40;
   localparam int BUSY_LONG = 150;
   localparam int DEPTH     = 4;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       rs_i = 1'b0;
   logic       en_i = 1'b0;
   logic [7:0] lcd_data_i = 8'h00;
   logic       host_ready_i = 1'b0;
   logic [8:0] data_o;
   logic       data_valid_o;
   logic       busy_o;
   logic       err_short_pulse_o;
   logic       err_busy_write_o;
   logic       err_overflow_o;

   always #5 clk = ~clk;

   lcd_bus_rx #(
      .MIN_EN_CYCLES    (MIN_EN),
      .BUSY_CYCLES      (BUSY),
      .BUSY_LONG_CYCLES (BUSY_LONG),
      .FIFO_DEPTH       (DEPTH)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .rs_i              (rs_i),
      .en_i              (en_i),
      .lcd_data_i        (lcd_data_i),
      .data_o            (data_o),
      .data_valid_o      (data_valid_o),
      .host_ready_i      (host_ready_i),
      .busy_o            (busy_o),
      .err_short_pulse_o (err_short_pulse_o),
      .err_busy_write_o  (err_busy_write_o),
      .err_overflow_o    (err_overflow_o)
   );

   int checks   = 0;
   int failures = 0;

   // Model: n = edges so far; busy is seen after edge m while m < busy_end.
   logic [8:0] m_q[$];
   logic       m_prev_en   = 1'b0;
   logic [8:0] m_prev_word = 9'h000;
   int         m_run       = 0;
   longint     n           = 0;
   longint     busy_end    = 0;
   bit         e_short, e_busy, e_ovf;

   int         busy_cnt, short_cnt, bw_cnt, ovf_cnt, vcnt;
   logic [8:0] last_word;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, n);
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic rs,
                       input logic [7:0] d, input logic rdy);
      bit         fall, pop, busy_now, do_push;
      logic [8:0] w;
      rst_i = rst; en_i = en; rs_i = rs; lcd_data_i = d; host_ready_i = rdy;
      e_short = 0; e_busy = 0; e_ovf = 0; do_push = 0;
      busy_now = (n < busy_end);
      if (rst) begin
         m_q.delete();
         busy_end  = 0;
         m_prev_en = 1'b0;
         m_run     = 0;
      end else begin
         fall = m_prev_en && !en;
         pop  = (m_q.size() != 0) && rdy;
         w    = m_prev_word;
         if (fall) begin
            if (m_run < MIN_EN)            e_short = 1;
            else if (busy_now)             e_busy  = 1;
            else begin
               if (m_q.size() == DEPTH) e_ovf = 1;
               else                     do_push = 1;
               busy_end = n + 1 + ((!w[8] && w[7:0] <= 8'd3) ? BUSY_LONG : BUSY);
            end
         end
         if (pop) void'(m_q.pop_front());
         if (do_push) m_q.push_back(w);
         m_run     = en ? m_run + 1 : 0;
         m_prev_en = en;
      end
      m_prev_word = {rs, d};
      n++;
      @(posedge clk);
      #1;
      chk("valid", data_valid_o, (m_q.size() != 0));
      chk("data", data_o, (m_q.size() != 0) ? m_q[0] : 9'h000);
      chk("busy", busy_o, (n < busy_end));
      chk("err_short", err_short_pulse_o, e_short);
      chk("err_busy", err_busy_write_o, e_busy);
      chk("err_ovf", err_overflow_o, e_ovf);
      busy_cnt  += int'(busy_o);
      short_cnt += int'(err_short_pulse_o);
      bw_cnt    += int'(err_busy_write_o);
      ovf_cnt   += int'(err_overflow_o);
      if (data_valid_o) begin
         vcnt++;
         last_word = data_o;
      end
   endtask

   task automatic pulse(input logic rs, input logic [7:0] d, input int width, input logic rdy);
      for (int i = 0; i < width; i++) step(1'b0, 1'b1, rs, d, rdy);
      step(1'b0, 1'b0, 1'($urandom), 8'($urandom), rdy);
   endtask

   task automatic idle(input int cycles, input logic rdy);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'($urandom), 8'($urandom), rdy);
   endtask

   task automatic idle_rand(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
   endtask

   task automatic clear_stats();
      busy_cnt = 0; short_cnt = 0; bw_cnt = 0; ovf_cnt = 0; vcnt = 0; last_word = 9'h000;
   endtask

   initial begin
      clear_stats();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("reset_valid", data_valid_o, 1'b0);
      chk("reset_busy", busy_o, 1'b0);

      // ordinary write
      clear_stats();
      pulse(1'b1, 8'h41, 23, 1'b1);
      idle(BUSY + 10, 1'b1);
      chk("write_busy_len", busy_cnt, BUSY);
      chk("write_valid_cycles", vcnt, 1);
      chk("write_word", last_word, 9'h141);

      // clear / home / ordinary instruction busy lengths
      clear_stats();
      pulse(1'b0, 8'h01, 25, 1'b1);
      idle(BUSY_LONG + 10, 1'b1);
      chk("clear_busy_len", busy_cnt, BUSY_LONG);
      chk("clear_word", last_word, 9'h001);
      clear_stats();
      pulse(1'b0, 8'h03, 25, 1'b1);
      idle(BUSY_LONG + 10, 1'b1);
      chk("home_busy_len", busy_cnt, BUSY_LONG);
      clear_stats();
      pulse(1'b0, 8'h04, 25, 1'b1);
      idle(BUSY_LONG + 10, 1'b1);
      chk("entry_busy_len", busy_cnt, BUSY);

      // short pulse, then a minimum-width pulse
      clear_stats();
      pulse(1'b1, 8'h5a, 22, 1'b1);
      idle(5, 1'b1);
      chk("short_count", short_cnt, 1);
      chk("short_no_busy", busy_cnt, 0);
      chk("short_no_word", vcnt, 0);
      pulse(1'b1, 8'h5b, 23, 1'b1);
      idle(BUSY + 5, 1'b1);
      chk("min_width_busy", busy_cnt, BUSY);
      chk("min_width_word", last_word, 9'h15b);

      // write while busy
      clear_stats();
      pulse(1'b1, 8'h55, 23, 1'b0);
      idle(5, 1'b0);
      pulse(1'b1, 8'h66, 23, 1'b0);
      idle(BUSY, 1'b0);
      chk("busy_wr_count", bw_cnt, 1);
      chk("busy_wr_len", busy_cnt, BUSY);
      chk("busy_wr_head", data_o, 9'h155);
      idle(3, 1'b1);
      chk("busy_wr_drained", data_valid_o, 1'b0);

      // overflow and ordered drain under backpressure
      clear_stats();
      for (int i = 0; i < 5; i++) begin
         pulse(1'b1, 8'h30 + 8'(i), 23, 1'b0);
         idle(BUSY + 5, 1'b0);
      end
      chk("ovf_count", ovf_cnt, 1);
      idle(4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", data_o, 32'h130 + 32'(i));
         step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      end
      chk("drain_empty", data_valid_o, 1'b0);

      // reset in the middle of a pulse with words queued and busy active
      clear_stats();
      pulse(1'b1, 8'h21, 23, 1'b0);
      idle(BUSY + 2, 1'b0);
      pulse(1'b1, 8'h22, 23, 1'b0);
      idle(3, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 8'h23, 1'b0);
      step(1'b1, 1'b1, 1'b1, 8'h23, 1'b0);
      chk("rst_valid", data_valid_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_data", data_o, 9'h000);
      clear_stats();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'h23, 1'b1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      idle(3, 1'b1);
      chk("rst_straddle_short", short_cnt, 1);
      chk("rst_straddle_no_word", vcnt, 0);

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         logic [7:0] d;
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         pulse(1'($urandom), d, int'($urandom_range(MIN_EN - 4, MIN_EN + 5)), 1'($urandom));
         idle_rand(int'($urandom_range(0, 70)));
      end
      idle(BUSY_LONG + 5, 1'b1);
      chk("final_idle", busy_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
